// File: rtl/vga_pkg.sv
// vga_pkg: framebuffer geometry, coordinate widths and drawing-engine states
package vga_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int COLOUR_W = 3;
    localparam int C_W = 10;
    typedef enum logic [2:0] {IDLE, CLEAR, INIT, DRAW, DONE} state_t;
endpackage

// File: rtl/circle_octant_point.sv
// circle_octant_point: maps (centre, offsets, octant) to a signed pixel and its on-screen test
module circle_octant_point #(
    parameter int SCREEN_W = vga_pkg::SCREEN_W,
    parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
    input  logic [vga_pkg::X_W-1:0]        cx,
    input  logic [vga_pkg::Y_W-1:0]        cy,
    input  logic signed [vga_pkg::C_W-1:0] ox,
    input  logic signed [vga_pkg::C_W-1:0] oy,
    input  logic [2:0]                     k,
    output logic signed [vga_pkg::C_W-1:0] x,
    output logic signed [vga_pkg::C_W-1:0] y,
    output logic                           on_screen
);
    import vga_pkg::*;
    localparam logic signed [C_W-1:0] X_END = C_W'(SCREEN_W);
    localparam logic signed [C_W-1:0] Y_END = C_W'(SCREEN_H);
    logic signed [C_W-1:0] dx, dy;
    // odd octants swap the offsets; x is negated in octants 2..5, y in 4..7
    always_comb begin
        dx = k[0] ? oy : ox;
        dy = k[0] ? ox : oy;
        x = $signed({{(C_W-X_W){1'b0}}, cx}) + ((k[2] ^ k[1]) ? -dx : dx);
        y = $signed({{(C_W-Y_W){1'b0}}, cy}) + (k[2] ? -dy : dy);
        on_screen = !x[C_W-1] && x < X_END && !y[C_W-1] && y < Y_END;
    end
endmodule

// File: rtl/circle_drawer.sv
// circle_drawer: optional full-screen clear, then midpoint circle rasterisation,
// one registered pixel write per cycle towards the VGA adapter
module circle_drawer #(
    parameter int SCREEN_W    = vga_pkg::SCREEN_W,
    parameter int SCREEN_H    = vga_pkg::SCREEN_H,
    parameter bit CLEAR_FIRST = 1'b1
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         start,
    input  logic [vga_pkg::X_W-1:0]      centre_x,
    input  logic [vga_pkg::Y_W-1:0]      centre_y,
    input  logic [6:0]                   radius,
    input  logic [vga_pkg::COLOUR_W-1:0] colour_in,
    output logic [vga_pkg::X_W-1:0]      xCoord,
    output logic [vga_pkg::Y_W-1:0]      yCoord,
    output logic [vga_pkg::COLOUR_W-1:0] color,
    output logic                         plot,
    output logic                         done
);
    import vga_pkg::*;
    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

    state_t state, state_n;
    logic [X_W-1:0] cx_q, px, px_n, x_n;
    logic [Y_W-1:0] cy_q, py, py_n, y_n;
    logic [6:0] r_q;
    logic [COLOUR_W-1:0] col_q, col_n;
    logic [2:0] k, k_n;
    logic signed [C_W-1:0] ox, oy, crit, ox_n, oy_n, crit_n, pt_x, pt_y;
    logic on_screen, plot_n;

    // the point unit sees next-cycle values so each candidate is registered straight out
    circle_octant_point #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_point (
        .cx(cx_q), .cy(cy_q), .ox(ox_n), .oy(oy_n), .k(k_n),
        .x(pt_x), .y(pt_y), .on_screen(on_screen)
    );

    always_comb begin
        state_n = state;
        px_n = px;
        py_n = py;
        k_n = k;
        ox_n = ox;
        oy_n = oy;
        crit_n = crit;
        case (state)
            IDLE: if (start) begin
                state_n = CLEAR_FIRST ? CLEAR : INIT;
                px_n = '0;
                py_n = '0;
            end
            CLEAR: if (px == X_LAST && py == Y_LAST) state_n = INIT;
            else begin
                px_n = (px == X_LAST) ? '0 : px + 1'b1;
                py_n = (px == X_LAST) ? py + 1'b1 : py;
            end
            INIT: begin
                state_n = DRAW;
                k_n = 3'd0;
                ox_n = $signed({{(C_W-7){1'b0}}, r_q});
                oy_n = '0;
                crit_n = 10'sd1 - $signed({{(C_W-7){1'b0}}, r_q});
            end
            DRAW: begin
                k_n = k + 3'd1;
                if (k == 3'd7) begin
                    oy_n = oy + 10'sd1;
                    ox_n = (crit <= 10'sd0) ? ox : ox - 10'sd1;
                    crit_n = crit + (((crit <= 10'sd0) ? oy_n : oy_n - ox_n) <<< 1) + 10'sd1;
                    if (oy_n > ox_n) state_n = DONE;
                end
            end
            DONE: if (!start) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        plot_n = 1'b0;
        x_n = xCoord;
        y_n = yCoord;
        col_n = color;
        if (state_n == CLEAR) begin
            plot_n = 1'b1;
            x_n = px_n;
            y_n = py_n;
            col_n = '0;
        end else if (state_n == DRAW && on_screen) begin
            plot_n = 1'b1;
            x_n = X_W'(pt_x);
            y_n = Y_W'(pt_y);
            col_n = col_q;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
            xCoord <= '0;
            yCoord <= '0;
            color <= '0;
            plot <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            xCoord <= x_n;
            yCoord <= y_n;
            color <= col_n;
            plot <= plot_n;
            done <= (state_n == DONE);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        px <= px_n;
        py <= py_n;
        k <= k_n;
        ox <= ox_n;
        oy <= oy_n;
        crit <= crit_n;
        if (state == IDLE && start) begin
            cx_q <= centre_x;
            cy_q <= centre_y;
            r_q <= radius;
            col_q <= colour_in;
        end
    end
endmodule

// File: tb/tb_circle_drawer.sv
// tb_circle_drawer: table-driven and randomized checks of both CLEAR_FIRST variants
// against a plain-integer midpoint circle model
module tb_circle_drawer;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [7:0] centre_x = '0;
    logic [6:0] centre_y = '0, radius = '0;
    logic [2:0] colour_in = '0;
    logic [7:0] x0, x1, xs;
    logic [6:0] y0, y1, ys;
    logic [2:0] c0, c1, cs;
    logic p0, p1, d0, d1, ps, ds;
    bit use1 = 1'b0;
    int checks = 0, passes = 0;

    always #5 clk = ~clk;

    circle_drawer #(.CLEAR_FIRST(1'b1)) dut1 (
        .CLOCK_50(clk), .reset(reset), .start(start), .centre_x(centre_x),
        .centre_y(centre_y), .radius(radius), .colour_in(colour_in),
        .xCoord(x1), .yCoord(y1), .color(c1), .plot(p1), .done(d1)
    );
    circle_drawer #(.CLEAR_FIRST(1'b0)) dut0 (
        .CLOCK_50(clk), .reset(reset), .start(start), .centre_x(centre_x),
        .centre_y(centre_y), .radius(radius), .colour_in(colour_in),
        .xCoord(x0), .yCoord(y0), .color(c0), .plot(p0), .done(d0)
    );

    assign xs = use1 ? x1 : x0;
    assign ys = use1 ? y1 : y0;
    assign cs = use1 ? c1 : c0;
    assign ps = use1 ? p1 : p0;
    assign ds = use1 ? d1 : d0;

    typedef struct {int plot; int x; int y;} pix_t;
    typedef struct {bit cf; int cx; int cy; int r; int col; int cyc; int plots;} vec_t;
    pix_t exp_q[$];

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    // every candidate of every midpoint iteration, in octant order, with its visibility
    task automatic build(input int cx, input int cy, input int r);
        int sx[8] = '{1, 1, -1, -1, -1, -1, 1, 1};
        int sy[8] = '{1, 1, 1, 1, -1, -1, -1, -1};
        int ox = r, oy = 0, crit = 1 - r, a, b, x, y;
        exp_q.delete();
        while (oy <= ox) begin
            for (int k = 0; k < 8; k++) begin
                a = (k % 2 == 1) ? oy : ox;
                b = (k % 2 == 1) ? ox : oy;
                x = cx + sx[k] * a;
                y = cy + sy[k] * b;
                exp_q.push_back('{(x >= 0 && x < 160 && y >= 0 && y < 120) ? 1 : 0, x, y});
            end
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end
    endtask

    task automatic scramble_inputs();
        centre_x = 8'($urandom);
        centre_y = 7'($urandom);
        radius = 7'($urandom);
        colour_in = 3'($urandom);
    endtask

    task automatic run_circle(input bit cf, input int cx, input int cy, input int r, input int col,
                              input bit hold, input bit scramble, input bit rst,
                              output int cycles, output int plots);
        pix_t obs[$];
        int errs, colerrs, offs, n;
        build(cx, cy, r);
        use1 = cf;
        if (rst) begin
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
        end
        @(negedge clk);
        centre_x = 8'(cx);
        centre_y = 7'(cy);
        radius = 7'(r);
        colour_in = 3'(col);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        if (cf) begin
            errs = 0;
            for (int i = 0; i < 19200; i++) begin
                if (ps !== 1'b1 || cs !== 3'd0 || int'(xs) != i % 160 || int'(ys) != i / 160) errs++;
                if (i == 0) begin
                    check("clear_first_x", int'(xs), 0);
                    check("clear_first_y", int'(ys), 0);
                end
                if (i == 19199) begin
                    check("clear_last_x", int'(xs), 159);
                    check("clear_last_y", int'(ys), 119);
                end
                if (scramble) scramble_inputs();
                @(negedge clk);
            end
            check("clear_seq_errs", errs, 0);
        end
        check("init_plot", int'(ps), 0);
        check("init_done", int'(ds), 0);
        @(negedge clk);
        cycles = 0;
        plots = 0;
        colerrs = 0;
        offs = 0;
        while (ds !== 1'b1 && cycles < 3000) begin
            obs.push_back('{int'(ps), int'(xs), int'(ys)});
            if (ps === 1'b1) begin
                plots++;
                if (int'(cs) != col) colerrs++;
                if (int'(xs) > 159 || int'(ys) > 119) offs++;
            end
            if (scramble) scramble_inputs();
            @(negedge clk);
            cycles++;
        end
        check("draw_reached_done", int'(ds), 1);
        check("draw_cycles", cycles, exp_q.size());
        errs = 0;
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (obs[i].plot != exp_q[i].plot ||
                (exp_q[i].plot == 1 && (obs[i].x != exp_q[i].x || obs[i].y != exp_q[i].y))) errs++;
        check("draw_seq_errs", errs, 0);
        check("draw_colour_errs", colerrs, 0);
        check("offscreen_plots", offs, 0);
        check("done_plot", int'(ps), 0);
        if (hold) begin
            errs = 0;
            repeat (6) begin
                @(negedge clk);
                if (ds !== 1'b1 || ps !== 1'b0) errs++;
            end
            check("done_hold_errs", errs, 0);
            start = 1'b0;
        end
        @(negedge clk);
        check("done_release", int'(ds), 0);
    endtask

    initial begin
        vec_t vecs[5];
        int meas[5];
        int cyc, pl, errs;
        vecs[0] = '{1'b1, 80, 60, 0, 5, 8, 8};
        vecs[1] = '{1'b0, 80, 60, 1, 4, 16, 16};
        vecs[2] = '{1'b0, 0, 0, 10, 2, 64, 18};
        vecs[3] = '{1'b0, 80, 60, 10, 7, 64, 64};
        vecs[4] = '{1'b0, 159, 119, 5, 6, 32, 10};

        repeat (3) @(negedge clk);
        check("rst_x", int'(x0), 0);
        check("rst_y", int'(y0), 0);
        check("rst_color", int'(c0), 0);
        check("rst_plot0", int'(p0), 0);
        check("rst_done0", int'(d0), 0);
        check("rst_plot1", int'(p1), 0);
        check("rst_done1", int'(d1), 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_circle(vecs[i].cf, vecs[i].cx, vecs[i].cy, vecs[i].r, vecs[i].col, 1'b0, 1'b0, 1'b1, cyc, pl);
            check("vec_cycles", cyc, vecs[i].cyc);
            check("vec_plots", pl, vecs[i].plots);
            meas[i] = cyc;
        end
        check("clip_timing_equal", meas[2], meas[3]);

        // hold start through completion, then a fresh pulse for a second circle
        run_circle(1'b0, 40, 30, 3, 5, 1'b1, 1'b0, 1'b1, cyc, pl);
        run_circle(1'b0, 100, 50, 4, 6, 1'b0, 1'b0, 1'b0, cyc, pl);

        // reset in the middle of a large circle
        use1 = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        centre_x = 8'd80;
        centre_y = 7'd60;
        radius = 7'd50;
        colour_in = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (101) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_plot", int'(p0), 0);
        check("midrst_done", int'(d0), 0);
        check("midrst_x", int'(x0), 0);
        reset = 1'b0;
        errs = 0;
        repeat (3) begin
            @(negedge clk);
            if (p0 !== 1'b0 || d0 !== 1'b0) errs++;
        end
        check("midrst_idle_errs", errs, 0);
        run_circle(1'b0, 20, 100, 9, 3, 1'b0, 1'b0, 1'b0, cyc, pl);

        // inputs churn throughout clear and draw; captured values must be used
        run_circle(1'b1, 70, 50, 20, 2, 1'b1, 1'b1, 1'b1, cyc, pl);

        for (int i = 0; i < 6; i++)
            run_circle(1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                       int'($urandom_range(0, 127)), int'($urandom_range(0, 7)),
                       1'b0, 1'b0, 1'b1, cyc, pl);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
